mem_port_arbiter: RTL

- Sequences a single-ported unified instruction/data backing memory and shares it between the core's instruction-fetch requester (I, read-only) and data requester (D, read/write).
- Sits between the core-side memory bus and the memory array/model.
- Converts per-requester request/hold signalling into one memory transaction at a time, and generates per-requester wait (stall) signals.
- Includes a watchdog that aborts transactions the memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/requester types and constants for mem_port_arbiter.
package mem_arb_pkg;

   // Sequencer states: arbitrate, run one memory transaction, pulse done.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   // Requester identity; the value doubles as the bit index into the request vector.
   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   // Read data returned to a requester whose transaction was aborted by the watchdog.
   // Wide enough for any practical word; users slice the low DATA_W bits.
   localparam int unsigned ERR_RDATA_MAX_W = 256;
   localparam logic [ERR_RDATA_MAX_W-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way combinational grant between the fetch (I) and data (D) requesters.
// Build option: define MEM_ARB_DPRIO_EN to make D win every simultaneous request;
// otherwise simultaneous requests alternate based on the previous winner.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last_gnt,
   output logic       gnt_valid,
   output req_id_t    gnt_id
);

   // Select the winner; a lone requester always wins.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the block can infer a latch.
      gnt_valid = |req;
      gnt_id    = REQ_I;
`ifdef MEM_ARB_DPRIO_EN
      if (req[REQ_D]) begin
         gnt_id = REQ_D;
      end
`else
      if (req[REQ_I] && req[REQ_D]) begin
         gnt_id = (last_gnt == REQ_D) ? REQ_I : REQ_D;
      end else if (req[REQ_D]) begin
         gnt_id = REQ_D;
      end
`endif
   end

`ifdef MEM_ARB_DPRIO_EN
   // Fixed priority ignores the previous winner.
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between an instruction-fetch
// requester (read-only) and a data requester (read/write). One transaction at a
// time: IDLE arbitrates and latches the request, BUSY drives the memory until
// mem_ack or the watchdog fires, DONE pulses the winner's done for one cycle.
// Build option: MEM_ARB_DPRIO_EN (see rr_arb2) selects fixed D priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   // instruction fetch requester
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   output logic              i_wait,
   // data requester
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_wait,
   // memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   // sticky watchdog flag
   output logic              err
);

   localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   arb_state_t       state;
   req_id_t          last_gnt;
   req_id_t          cur_id;
   logic [CNT_W-1:0] cnt;
   logic             gnt_valid;
   req_id_t          gnt_id;

   rr_arb2 u_arb (
      .req       ({d_req, i_req}),
      .last_gnt  (last_gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // Stall each requester until its done pulse arrives.
   assign i_wait = i_req & ~i_done;
   assign d_wait = d_req & ~d_done;

   // Arbitration, transaction sequencing, watchdog and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_gnt  <= REQ_D;
         cur_id    <= REQ_I;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         err       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register here updates from pre-edge values.
         i_done <= 1'b0;
         d_done <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  cur_id   <= gnt_id;
                  last_gnt <= gnt_id;
                  cnt      <= '0;
                  mem_req  <= 1'b1;
                  if (gnt_id == REQ_D) begin
                     mem_we    <= d_we;
                     mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata <= d_wdata;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata <= '0;
                  end
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ack || (cnt == CNT_LAST)) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= DONE;
                  if (cur_id == REQ_D) begin
                     d_done <= 1'b1;
                  end else begin
                     i_done <= 1'b1;
                  end
                  if (!mem_ack) begin
                     // Watchdog abort: flag it and hand back the error pattern.
                     err <= 1'b1;
                     if (cur_id == REQ_D) begin
                        d_rdata <= ERR_RDATA[DATA_W-1:0];
                     end else begin
                        i_rdata <= ERR_RDATA[DATA_W-1:0];
                     end
                  end else if (!mem_we) begin
                     if (cur_id == REQ_D) begin
                        d_rdata <= mem_rdata;
                     end else begin
                        i_rdata <= mem_rdata;
                     end
                  end
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
